// File: rtl/pakin_mux.sv
// pakin_mux: per-channel packet assembly into messages, arbitrated into a FIFO and sent over a two-phase handshake.
// Latency: last packet -> FIFO 1 cycle -> snd0_req 1 cycle; a full FIFO stalls slots and rcv_ack. PAKIN_MUX_RR_EN selects round-robin.
module pakin_mux #(
  parameter int PSZ     = 8,
  parameter int TOT_PKS = 4,
  parameter int NCH     = 2,
  parameter int FSZ     = 4,
  localparam int MSZ    = PSZ * TOT_PKS,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               i_clk,
  input  logic               reset,
  output logic               ready,
  input  logic [NCH-1:0]     rcv_req,
  output logic [NCH-1:0]     rcv_ack,
  input  logic [NCH*PSZ-1:0] rcv_pak,
  output logic               snd0_req,
  input  logic               snd0_ack,
  output logic [MSZ-1:0]     snd0_msg,
  output logic [CW-1:0]      snd0_chn
);

  localparam int CNTW = (TOT_PKS > 1) ? $clog2(TOT_PKS) : 1;
  localparam int AW   = $clog2(FSZ);
  localparam int EW   = MSZ + CW;

  logic [CNTW-1:0] cnt [NCH];
  logic [MSZ-1:0]  slot_dat [NCH];
  logic [NCH-1:0]  slot_full;
  logic [NCH-1:0]  acc;
  logic [EW-1:0]   mem [FSZ];
  logic [AW:0]     wptr, rptr;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic            gnt_vld;
  logic [CW-1:0]   gnt_idx;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop        = (snd0_req == snd0_ack) && !fifo_empty;
  // A pop in the same cycle frees an entry, so a full FIFO can still take a push.
  assign push       = gnt_vld && (!fifo_full || pop);
  assign acc        = {NCH{ready}} & (rcv_req ^ rcv_ack) & ~slot_full;

`ifdef PAKIN_MUX_RR_EN
  logic [CW-1:0] last_gnt;

  always_comb begin
    int c;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    c       = 0;
    for (int i = 0; i < NCH; i++) begin
      c = int'(last_gnt) + 1 + i;
      if (c >= NCH) c = c - NCH;
      if (!gnt_vld && slot_full[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(c);
      end
    end
  end

  // Reset to the top channel so the first search starts at channel 0.
  always_ff @(posedge i_clk) begin
    if (reset)     last_gnt <= CW'(NCH - 1);
    else if (push) last_gnt <= gnt_idx;
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (slot_full[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(i);
      end
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (reset) begin
      ready     <= 1'b0;
      rcv_ack   <= '0;
      slot_full <= '0;
      wptr      <= '0;
      rptr      <= '0;
      snd0_req  <= 1'b0;
      snd0_msg  <= '0;
      snd0_chn  <= '0;
      for (int k = 0; k < NCH; k++) cnt[k] <= '0;
    end else begin
      ready <= 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (acc[k]) begin
          rcv_ack[k] <= ~rcv_ack[k];
          if (cnt[k] == CNTW'(TOT_PKS - 1)) begin
            cnt[k]       <= '0;
            slot_full[k] <= 1'b1;
          end else begin
            cnt[k] <= cnt[k] + 1'b1;
          end
        end
      end
      // A granted slot is full, so it cannot be accepting in the same cycle.
      if (push) begin
        slot_full[gnt_idx] <= 1'b0;
        wptr               <= wptr + 1'b1;
      end
      if (pop) begin
        {snd0_msg, snd0_chn} <= mem[rptr[AW-1:0]];
        rptr                 <= rptr + 1'b1;
        snd0_req             <= ~snd0_req;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (acc[k]) slot_dat[k][cnt[k]*PSZ +: PSZ] <= rcv_pak[k*PSZ +: PSZ];
    end
    if (push) mem[wptr[AW-1:0]] <= {slot_dat[gnt_idx], gnt_idx};
  end

endmodule

// File: tb/tb_pakin_mux.sv
// Scoreboard bench for pakin_mux: expected messages are queued as stimulus is driven and popped at the output handshake.
module tb_pakin_mux;
  localparam int PSZ     = 8;
  localparam int TOT_PKS = 4;
  localparam int NCH     = 2;
  localparam int FSZ     = 4;
  localparam int MSZ     = PSZ * TOT_PKS;
  localparam int CW      = 1;

  typedef struct packed {
    logic [MSZ-1:0] msg;
    logic [CW-1:0]  chn;
  } exp_t;

  logic               i_clk = 1'b0;
  logic               reset;
  logic               ready;
  logic [NCH-1:0]     rcv_req;
  logic [NCH-1:0]     rcv_ack;
  logic [NCH*PSZ-1:0] rcv_pak;
  logic               snd0_req;
  logic               snd0_ack;
  logic [MSZ-1:0]     snd0_msg;
  logic [CW-1:0]      snd0_chn;

  logic           req_ch [NCH];
  logic [PSZ-1:0] pak_ch [NCH];
  exp_t           sb_q [$];
  int             checks = 0;
  int             errors = 0;
  int             ack_tog [NCH];

  always #5 i_clk = ~i_clk;

  for (genvar k = 0; k < NCH; k++) begin : g_drv
    assign rcv_req[k]             = req_ch[k];
    assign rcv_pak[k*PSZ +: PSZ]  = pak_ch[k];
  end

  pakin_mux #(.PSZ(PSZ), .TOT_PKS(TOT_PKS), .NCH(NCH), .FSZ(FSZ)) dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .ready    (ready),
    .rcv_req  (rcv_req),
    .rcv_ack  (rcv_ack),
    .rcv_pak  (rcv_pak),
    .snd0_req (snd0_req),
    .snd0_ack (snd0_ack),
    .snd0_msg (snd0_msg),
    .snd0_chn (snd0_chn)
  );

  // Counts rcv_ack edges per channel.
  initial begin
    logic [NCH-1:0] prev;
    prev = '0;
    for (int k = 0; k < NCH; k++) ack_tog[k] = 0;
    forever begin
      @(posedge i_clk);
      #1;
      for (int k = 0; k < NCH; k++) if (rcv_ack[k] !== prev[k]) ack_tog[k]++;
      prev = rcv_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: still running at time %0t, required completion earlier", $time);
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(input logic [MSZ-1:0] msg, input logic [CW-1:0] chn);
    exp_t e;
    e.msg = msg;
    e.chn = chn;
    return e;
  endfunction

  // Called at a negedge; offers packets first..last of msg on channel ch.
  task automatic send_pkts(input int ch, input logic [MSZ-1:0] msg, input int first, input int last);
    for (int p = first; p <= last; p++) begin
      int n;
      pak_ch[ch] = msg[p*PSZ +: PSZ];
      req_ch[ch] = ~req_ch[ch];
      n = 0;
      do begin
        @(negedge i_clk);
        n++;
      end while (rcv_ack[ch] !== req_ch[ch] && n < 100);
      checks++;
      if (rcv_ack[ch] !== req_ch[ch]) begin
        errors++;
        $display("FAIL send_ch%0d_pkt%0d: rcv_ack=%b after %0d cycles, required %b", ch, p, rcv_ack[ch], n, req_ch[ch]);
      end
    end
  endtask

  // Called at a negedge; waits for one output, checks it against the scoreboard, then acks.
  task automatic drain_one(input string name);
    exp_t e;
    int   n;
    n = 0;
    while (snd0_req === snd0_ack && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (snd0_req === snd0_ack) begin
      errors++;
      $display("FAIL %s: no snd0_req toggle within 200 cycles, required one", name);
      return;
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected output msg=%h chn=%0d, required none", name, snd0_msg, snd0_chn);
    end else begin
      e = sb_q.pop_front();
      if (snd0_msg !== e.msg || snd0_chn !== e.chn)
      begin
        errors++;
        $display("FAIL %s: msg=%h chn=%0d, required msg=%h chn=%0d", name, snd0_msg, snd0_chn, e.msg, e.chn);
      end
    end
    snd0_ack = snd0_req;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < NCH; k++) req_ch[k] = 1'b0;
    snd0_ack = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge i_clk);
    reset = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b, required 0", ready); end
    checks++; if (rcv_ack !== '0) begin errors++; $display("FAIL rst_rcv_ack: got %b, required 0", rcv_ack); end
    checks++; if (snd0_req !== 1'b0) begin errors++; $display("FAIL rst_snd0_req: got %b, required 0", snd0_req); end
    checks++; if (snd0_msg !== '0) begin errors++; $display("FAIL rst_snd0_msg: got %h, required 0", snd0_msg); end
    checks++; if (snd0_chn !== '0) begin errors++; $display("FAIL rst_snd0_chn: got %0d, required 0", snd0_chn); end
    reset = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_init_cycle: ready=%b, required 0", ready); end
    @(negedge i_clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: ready=%b, required 1", ready); end
  endtask

  task automatic test_single();
    int t0;
    t0 = ack_tog[0];
    sb_q.push_back(mk(32'h44332211, 1'b0));
    send_pkts(0, 32'h44332211, 0, 3);
    checks++; if (snd0_req !== snd0_ack) begin errors++; $display("FAIL lat_accept: snd0_req=%b, required %b", snd0_req, snd0_ack); end
    @(negedge i_clk);
    checks++; if (snd0_req !== snd0_ack) begin errors++; $display("FAIL lat_fifo_write: snd0_req=%b, required %b", snd0_req, snd0_ack); end
    @(negedge i_clk);
    checks++; if (snd0_req === snd0_ack) begin errors++; $display("FAIL lat_out: snd0_req=%b, required %b", snd0_req, ~snd0_ack); end
    drain_one("single_msg");
    repeat (10) @(negedge i_clk);
    checks++; if (snd0_req !== snd0_ack) begin errors++; $display("FAIL single_extra: snd0_req=%b, required %b", snd0_req, snd0_ack); end
    checks++; if (ack_tog[0] - t0 != 4) begin errors++; $display("FAIL single_ack_toggles: got %0d, required 4", ack_tog[0] - t0); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL single_sb: %0d left, required 0", sb_q.size()); end
  endtask

  task automatic test_arbitration();
    do_reset();
    sb_q.push_back(mk(32'hA3A2A1A0, 1'b0));
    sb_q.push_back(mk(32'hB3B2B1B0, 1'b1));
    fork
      send_pkts(0, 32'hA3A2A1A0, 0, 3);
      send_pkts(1, 32'hB3B2B1B0, 0, 3);
    join
    drain_one("arb1_first");
    drain_one("arb1_second");
    sb_q.push_back(mk(32'hC3C2C1C0, 1'b0));
    send_pkts(0, 32'hC3C2C1C0, 0, 3);
    drain_one("arb_solo_ch0");
`ifdef PAKIN_MUX_RR_EN
    sb_q.push_back(mk(32'hD3D2D1D0, 1'b1));
    sb_q.push_back(mk(32'hE3E2E1E0, 1'b0));
`else
    sb_q.push_back(mk(32'hE3E2E1E0, 1'b0));
    sb_q.push_back(mk(32'hD3D2D1D0, 1'b1));
`endif
    fork
      send_pkts(0, 32'hE3E2E1E0, 0, 3);
      send_pkts(1, 32'hD3D2D1D0, 0, 3);
    join
    drain_one("arb2_first");
    drain_one("arb2_second");
  endtask

  task automatic test_fifo_full();
    logic [MSZ-1:0] m [7];
    int t0;
    do_reset();
    for (int i = 0; i < 7; i++) m[i] = 32'hC0C1C2C3 + 32'(i) * 32'h01020304;
    t0 = ack_tog[0];
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(mk(m[i], 1'b0));
      send_pkts(0, m[i], 0, 3);
    end
    repeat (3) @(negedge i_clk);
    checks++; if (ack_tog[0] - t0 != 24) begin errors++; $display("FAIL full_acks: got %0d, required 24", ack_tog[0] - t0); end
    checks++; if (snd0_req === snd0_ack) begin errors++; $display("FAIL full_out_busy: snd0_req=%b, required %b", snd0_req, ~snd0_ack); end
    sb_q.push_back(mk(m[6], 1'b0));
    pak_ch[0] = m[6][PSZ-1:0];
    req_ch[0] = ~req_ch[0];
    repeat (6) @(negedge i_clk);
    checks++; if (rcv_ack[0] === req_ch[0]) begin errors++; $display("FAIL full_stall: rcv_ack[0]=%b, required %b", rcv_ack[0], ~req_ch[0]); end
    drain_one("full_msg0");
    checks++; if (snd0_req === snd0_ack) begin errors++; $display("FAIL full_reload: snd0_req=%b, required %b", snd0_req, ~snd0_ack); end
    @(negedge i_clk);
    checks++; if (rcv_ack[0] !== req_ch[0]) begin errors++; $display("FAIL full_push_pop: rcv_ack[0]=%b, required %b", rcv_ack[0], req_ch[0]); end
    send_pkts(0, m[6], 1, 3);
    for (int i = 1; i < 7; i++) drain_one($sformatf("full_msg%0d", i));
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL full_sb: %0d left, required 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    send_pkts(1, 32'hDEADBEEF, 0, 1);
    reset = 1'b1;
    for (int k = 0; k < NCH; k++) req_ch[k] = 1'b0;
    snd0_ack = 1'b0;
    sb_q.delete();
    @(negedge i_clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b, required 0", ready); end
    checks++; if (rcv_ack !== '0) begin errors++; $display("FAIL mid_rcv_ack: got %b, required 0", rcv_ack); end
    checks++; if (snd0_req !== 1'b0) begin errors++; $display("FAIL mid_snd0_req: got %b, required 0", snd0_req); end
    reset = 1'b0;
    @(negedge i_clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready_rise: got %b, required 1", ready); end
    sb_q.push_back(mk(32'h0D0C0B0A, 1'b1));
    send_pkts(1, 32'h0D0C0B0A, 0, 3);
    drain_one("mid_clean_msg");
    repeat (8) @(negedge i_clk);
    checks++; if (snd0_req !== snd0_ack) begin errors++; $display("FAIL mid_residue: snd0_req=%b, required %b", snd0_req, snd0_ack); end
  endtask

  initial begin
    reset    = 1'b1;
    snd0_ack = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      req_ch[k] = 1'b0;
      pak_ch[k] = '0;
    end
    @(negedge i_clk);
    test_reset();
    test_single();
    test_arbitration();
    test_fifo_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
